bus_arb: RTL
============

BUS_ARB -- requirements
Module: bus_arb

Interface
REQ-001 SHALL have parameter READ_DEPTH, default 4, meaning the maximum number of outstanding reads (power of two, 2..16).
REQ-002 SHALL have one clock; reset is asynchronous and active-high: port clock, input, 1, rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports m0_req_ready, output, 1, and m1_req_ready, output, 1: command accepted this cycle (m0 = host interface, m1 = CPU).
REQ-005 SHALL have ports mN_req_read, input, 1, and mN_req_write, input, 1, for N = 0, 1: command strobes, held until accepted.
REQ-006 SHALL have ports mN_req_address, input, 32, and mN_req_data, input, 32: byte address and write data.
REQ-007 SHALL have ports mN_res_valid, output, 1, and mN_res_data, output, 32: read response to requester N.
REQ-008 SHALL have downstream ports bus_req_ready, input, 1; bus_req_read, output, 1; bus_req_write, output, 1; bus_req_address, output, 32; bus_req_data, output, 32.
REQ-009 SHALL have ports bus_res_valid, input, 1, and bus_res_data, input, 32: in-order read responses.
REQ-010 SHALL have port orphan, output, 1: sticky flag for a response with no outstanding read.

Function
REQ-011 SHALL treat requester N as eligible when mN_req_write=1, or when mN_req_read=1 and the outstanding-read count is below READ_DEPTH.
REQ-012 SHALL grant combinationally in the same cycle: the only eligible requester wins; on a tie, the requester not recorded in register last wins.
REQ-013 SHALL drive the granted requester's address and data onto bus_req_*, and SHALL assert bus_req_read or bus_req_write only while a grant exists.
REQ-014 SHALL, when a requester asserts both read and write, forward only the read and suppress the write; the two strobes are never forwarded together.
REQ-015 SHALL drive mN_req_ready = bus_req_ready AND (granted == N), and SHALL hold the non-granted requester's ready at 0.
REQ-016 SHALL count a transfer when bus_req_ready=1 and a grant exists; on a transfer, last SHALL be updated to the granted index on the next edge.
REQ-017 SHALL push the granted index into a tag queue on each read transfer; writes SHALL NOT push.
REQ-018 SHALL, on bus_req_ready=0, hold last and the tag queue unchanged and re-evaluate arbitration every cycle; a grant is not sticky.
REQ-019 SHALL, on bus_res_valid=1 with a non-empty queue, pop the head tag and assert m{tag}_res_valid for that same cycle only (combinational, 0-cycle latency).
REQ-020 SHALL drive both m0_res_data and m1_res_data from bus_res_data at all times.
REQ-021 SHALL, on bus_res_valid=1 with an empty queue, assert no mN_res_valid and set orphan=1 until reset.
REQ-022 SHALL compute "full" from the registered count only, so a read is blocked when count == READ_DEPTH even if a pop occurs in the same cycle.
REQ-023 SHALL, on a simultaneous push and pop, leave the count unchanged and preserve FIFO order.
REQ-024 SHALL keep the count in $clog2(READ_DEPTH)+1 bits and wrap the queue pointers modulo READ_DEPTH.

Reset
REQ-025 SHALL, on reset=1 at any time including mid-transfer, asynchronously clear the count and queue pointers, clear orphan to 0, and set last=1 so m0 wins the first tie.
REQ-026 SHALL, while reset=1, drive all mN_req_ready and mN_res_valid to 0 and bus_req_read and bus_req_write to 0.
REQ-027 SHALL treat responses to pre-reset reads that arrive after reset as orphans (REQ-021).

Structure
REQ-028 SHALL place the requester-index width, the default READ_DEPTH, and the named requester indices (HOST=0, CPU=1) in the shared package/include.
REQ-029 SHALL implement the tag queue as one sub-module, bus_arb_tagq, a parameterized synchronous FIFO with push, pop, head, count, and full outputs.

Verification
REQ-030 SHALL verify a tie: both requesters read, address 0x100 (m0) and 0x200 (m1), bus_req_ready=1 -> m0 is granted first (0x100), then m1 (0x200).
REQ-031 SHALL verify responses: with reads from m0 then m1 outstanding, responses 0xAAAA0000 then 0xBBBB1111 -> m0_res_valid on the first and m1_res_valid on the second.
REQ-032 SHALL verify the full condition: READ_DEPTH=4, m1 issues 4 reads with no response -> a 5th m1 read is stalled while an m0 write to 0x40 data 0x12345678 still passes.
REQ-033 SHALL verify backpressure: bus_req_ready=0 for 3 cycles with m0 writing -> no ready and last unchanged; ready=1 -> a single transfer.
REQ-034 SHALL verify an orphan: bus_res_valid with an empty queue -> orphan=1 and no res_valid; orphan stays 1 until reset.
REQ-035 SHALL verify reset mid-operation: reset asserted with 2 reads outstanding -> count=0; the next response sets orphan, and m0 wins the next tie.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-requester bus arbiter.
//   REQ_IDX_W          : width of a requester index / tag
//   READ_DEPTH_DEFAULT : default maximum number of outstanding reads
//   HOST, CPU          : named requester indices (m0 = host interface, m1 = CPU)
package bus_arb_pkg;

  localparam int unsigned REQ_IDX_W          = 1;
  localparam int unsigned READ_DEPTH_DEFAULT = 4;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  localparam req_idx_t HOST = 1'b0;
  localparam req_idx_t CPU  = 1'b1;

endpackage

// File: rtl/bus_arb_tagq.sv
// Tag queue: synchronous FIFO of requester indices, one entry per outstanding read.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   push, push_data : enqueue a tag (caller must not push when full)
//   pop           : dequeue the head tag (caller must not pop when empty)
//   head          : oldest tag
//   count         : number of stored tags, 0..DEPTH
//   full          : count == DEPTH
module bus_arb_tagq #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 1,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the pointers cover them.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/bus_arb.sv
// Two-requester bus arbiter with in-order read response routing.
//   clock, reset        : rising-edge clock, asynchronous active-high reset
//   mN_req_*            : command from requester N (m0 = host, m1 = CPU)
//   mN_req_ready        : requester N's command accepted this cycle
//   mN_res_valid/data   : read response routed back to requester N
//   bus_req_*           : command to the downstream bus
//   bus_res_valid/data  : in-order read responses from the bus
//   orphan              : sticky, a response arrived with no outstanding read
module bus_arb
  import bus_arb_pkg::*;
#(
  parameter int unsigned READ_DEPTH = READ_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        m0_req_ready,
  input  logic        m0_req_read,
  input  logic        m0_req_write,
  input  logic [31:0] m0_req_address,
  input  logic [31:0] m0_req_data,
  output logic        m0_res_valid,
  output logic [31:0] m0_res_data,
  output logic        m1_req_ready,
  input  logic        m1_req_read,
  input  logic        m1_req_write,
  input  logic [31:0] m1_req_address,
  input  logic [31:0] m1_req_data,
  output logic        m1_res_valid,
  output logic [31:0] m1_res_data,
  input  logic        bus_req_ready,
  output logic        bus_req_read,
  output logic        bus_req_write,
  output logic [31:0] bus_req_address,
  output logic [31:0] bus_req_data,
  input  logic        bus_res_valid,
  input  logic [31:0] bus_res_data,
  output logic        orphan
);

  localparam int unsigned CNT_W = $clog2(READ_DEPTH) + 1;

  req_idx_t         last_q, last_d;
  logic             orphan_q, orphan_d;
  logic             elig0, elig1;
  logic             gnt_valid;
  req_idx_t         gnt_idx;
  logic             sel_read, sel_write;
  logic             xfer, push, pop;
  logic             rd_full, rd_empty;
  logic [CNT_W-1:0] rd_count;
  req_idx_t         rd_head;

  // A requester that raises read takes the read path only (its write is
  // suppressed), so a full queue blocks it even if write is also set.
  always_comb begin
    elig0 = m0_req_read ? !rd_full : m0_req_write;
    elig1 = m1_req_read ? !rd_full : m1_req_write;

    gnt_valid = !reset && (elig0 || elig1);
    if (elig0 && elig1) gnt_idx = ~last_q;
    else                gnt_idx = elig1 ? CPU : HOST;

    if (gnt_idx == CPU) begin
      sel_read        = m1_req_read;
      sel_write       = m1_req_write;
      bus_req_address = m1_req_address;
      bus_req_data    = m1_req_data;
    end else begin
      sel_read        = m0_req_read;
      sel_write       = m0_req_write;
      bus_req_address = m0_req_address;
      bus_req_data    = m0_req_data;
    end

    bus_req_read  = gnt_valid && sel_read;
    bus_req_write = gnt_valid && sel_write && !sel_read;

    m0_req_ready = bus_req_ready && gnt_valid && (gnt_idx == HOST);
    m1_req_ready = bus_req_ready && gnt_valid && (gnt_idx == CPU);

    xfer = bus_req_ready && gnt_valid;
    push = xfer && sel_read;
    pop  = !reset && bus_res_valid && !rd_empty;

    m0_res_valid = pop && (rd_head == HOST);
    m1_res_valid = pop && (rd_head == CPU);

    last_d   = xfer ? gnt_idx : last_q;
    orphan_d = orphan_q || (bus_res_valid && rd_empty);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q   <= CPU;
      orphan_q <= 1'b0;
    end else begin
      last_q   <= last_d;
      orphan_q <= orphan_d;
    end
  end

  bus_arb_tagq #(
    .DEPTH (READ_DEPTH),
    .WIDTH (REQ_IDX_W)
  ) u_tagq (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (gnt_idx),
    .pop       (pop),
    .head      (rd_head),
    .count     (rd_count),
    .full      (rd_full)
  );

  assign rd_empty    = (rd_count == '0);
  assign m0_res_data = bus_res_data;
  assign m1_res_data = bus_res_data;
  assign orphan      = orphan_q;

endmodule
